exmem_stage: RTL and testbench

EXMEM_STAGE -- requirements
Module: exmem_stage

---
 rtl/exmem_stage.sv | 151 +++++++++++++++
 tb/tb_exmem_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_stage.sv
// EX->MEM pipeline register with optional skid entry; optional feature macro: EXMEM_SKID_EN.
// Latency: 1 cycle from acceptance to presentation when the stage is empty or draining.
// Backpressure: skid build registers in_ready (= no skid beat held); plain build passes out_ready through.
module exmem_stage #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_data,
    input  logic [RD_W-1:0] in_rd,
    input  logic [5:0]      in_ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_data,
    output logic [RD_W-1:0] out_rd,
    output logic [5:0]      out_ctrl,
    output logic            branch_taken,
    output logic [1:0]      occupancy
);

    // Encodings double as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] data;
        logic [RD_W-1:0] rd;
        logic [5:0]      ctrl;
    } beat_t;

    state_t state;
    state_t state_nxt;
    beat_t  in_beat;
    beat_t  m_beat;
    logic   m_valid;
    logic   accept;
    logic   leave;
    logic   load_m;
`ifdef EXMEM_SKID_EN
    beat_t  s_beat;
    logic   load_s;
    logic   m_from_s;
    logic   in_ready_q;
`endif

    assign in_beat = '{pc: in_pc, result: in_result, data: in_data, rd: in_rd, ctrl: in_ctrl};
    assign m_valid = (state != ST_EMPTY);
    assign accept  = in_valid && in_ready && !flush;
    assign leave   = m_valid && out_ready;

    // Next-state and entry-load decode; flush overrides everything.
    always_comb begin
        state_nxt = state;
        load_m    = 1'b0;
`ifdef EXMEM_SKID_EN
        load_s    = 1'b0;
        m_from_s  = 1'b0;
`endif
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        load_m    = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && leave) begin
                        load_m = 1'b1;
`ifdef EXMEM_SKID_EN
                    end else if (accept) begin
                        state_nxt = ST_FULL;
                        load_s    = 1'b1;
`endif
                    end else if (leave) begin
                        state_nxt = ST_EMPTY;
                    end
                end
`ifdef EXMEM_SKID_EN
                ST_FULL: begin
                    // in_ready is low here, so only a departure can happen.
                    if (leave) begin
                        state_nxt = ST_ONE;
                        m_from_s  = 1'b1;
                    end
                end
`endif
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Payload registers; contents only change on an explicit load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_beat <= '0;
`ifdef EXMEM_SKID_EN
            s_beat <= '0;
`endif
        end else begin
            if (load_m) m_beat <= in_beat;
`ifdef EXMEM_SKID_EN
            else if (m_from_s) m_beat <= s_beat;
            if (load_s) s_beat <= in_beat;
`endif
        end
    end

`ifdef EXMEM_SKID_EN
    // Ready is precomputed from the next state so it never depends on out_ready this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) in_ready_q <= 1'b1;
        else        in_ready_q <= (state_nxt != ST_FULL);
    end
    assign in_ready = in_ready_q;
`else
    assign in_ready = out_ready | ~m_valid;
`endif

    assign out_valid    = m_valid;
    assign out_pc       = m_beat.pc;
    assign out_result   = m_beat.result;
    assign out_data     = m_beat.data;
    assign out_rd       = m_beat.rd;
    // Bubbles must never carry write/memory/branch side effects downstream.
    assign out_ctrl     = m_beat.ctrl & {6{m_valid}};
    assign branch_taken = m_valid & out_ctrl[1] & out_ctrl[0];
    assign occupancy    = state;

endmodule

// File: tb/tb_exmem_stage.sv
module tb_exmem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc, in_result, in_data;
    logic [4:0]  in_rd;
    logic [5:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc, out_result, out_data;
    logic [4:0]  out_rd;
    logic [5:0]  out_ctrl;
    logic        branch_taken;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exmem_stage #(.XLEN(64), .RD_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_result(in_result), .in_data(in_data),
        .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_result(out_result), .out_data(out_data),
        .out_rd(out_rd), .out_ctrl(out_ctrl),
        .branch_taken(branch_taken), .occupancy(occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_result = '0;
        in_data   = '0;
        in_rd     = '0;
        in_ctrl   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 6'b111111;
        out_ready = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL rst_occupancy got=%0d want=0", occupancy); end
        checks++; if (out_ctrl !== 6'b0) begin failures++; $display("FAIL rst_out_ctrl got=%b want=000000", out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
        checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL rst_branch got=%0b want=0", branch_taken); end
        // Release; the beat held on the inputs is accepted at the next edge.
        reset   = 1'b1;
        in_ctrl = 6'b100000;
        in_pc   = 64'h40;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h40) begin failures++; $display("FAIL rst_first_beat got v=%0b pc=%h want v=1 pc=40", out_valid, out_pc); end
        // Asynchronous reset while a beat is held.
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL rst_async got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
        tick();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 64'h44;
        tick();
        checks++; if (out_pc !== 64'h44 || occupancy !== 2'd1) begin failures++; $display("FAIL rst_reentry got pc=%h occ=%0d want pc=44 occ=1", out_pc, occupancy); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL rst_drain got occ=%0d want 0", occupancy); end
    endtask

    task automatic test_hold();
        idle_inputs();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 64'h100;
        tick();
        in_pc = 64'h104;
`ifdef EXMEM_SKID_EN
        tick();
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL hold_occ_full got=%0d want=2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready got=%0b want=0", in_ready); end
        checks++; if (out_pc !== 64'h100) begin failures++; $display("FAIL hold_out_pc got=%h want=100", out_pc); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_pc !== 64'h104 || occupancy !== 2'd1) begin failures++; $display("FAIL hold_second got pc=%h occ=%0d want pc=104 occ=1", out_pc, occupancy); end
        tick();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL hold_empty got occ=%0d v=%0b want 0/0", occupancy, out_valid); end
`else
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready got=%0b want=0", in_ready); end
        tick();
        checks++; if (out_pc !== 64'h100 || occupancy !== 2'd1) begin failures++; $display("FAIL hold_stall got pc=%h occ=%0d want pc=100 occ=1", out_pc, occupancy); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_comb got=%0b want=1", in_ready); end
        tick();
        checks++; if (out_pc !== 64'h104 || occupancy !== 2'd1) begin failures++; $display("FAIL hold_second got pc=%h occ=%0d want pc=104 occ=1", out_pc, occupancy); end
        in_valid = 1'b0;
        tick();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL hold_empty got occ=%0d v=%0b want 0/0", occupancy, out_valid); end
`endif
    endtask

    task automatic test_stream();
        logic [63:0] got[$];
        int          sent = 0;
        logic        tog  = 1'b1;
        idle_inputs();
        for (int cyc = 0; cyc < 80 && got.size() < 8; cyc++) begin
            in_valid  = (sent < 8);
            in_result = 64'(sent + 1);
            out_ready = tog;
            tog       = ~tog;
            @(negedge clk);
            if (out_valid && out_ready) got.push_back(out_result);
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (got.size() != 8) begin failures++; $display("FAIL stream_count got=%0d want=8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++; if (got[i] !== 64'(i + 1)) begin failures++; $display("FAIL stream_order idx=%0d got=%0d want=%0d", i, got[i], i + 1); end
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        int seen = 0;
        idle_inputs();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 64'h200;
        in_ctrl   = 6'b101110;
        tick();
        checks++; if (out_ctrl !== 6'b101110) begin failures++; $display("FAIL flush_ctrl_pass got=%b want=101110", out_ctrl); end
`ifdef EXMEM_SKID_EN
        in_pc = 64'h204;
        tick();
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_prefill got=%0d want=2", occupancy); end
`endif
        flush     = 1'b1;
        in_pc     = 64'hDEAD;
        in_ctrl   = 6'b111111;
        out_ready = 1'b1;
        tick();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_state got occ=%0d v=%0b want 0/0", occupancy, out_valid); end
        checks++; if (out_ctrl !== 6'b0 || branch_taken !== 1'b0) begin failures++; $display("FAIL flush_ctrl got ctrl=%b br=%0b want 0", out_ctrl, branch_taken); end
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_leak got=%0d want=0", seen); end
    endtask

    task automatic test_branch();
        idle_inputs();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 6'b000011;
        in_pc     = 64'hFFFF_FFFF_FFFF_FFFC;
        in_result = 64'hFEDC_BA98_7654_3210;
        in_data   = 64'h8000_0000_0000_0001;
        in_rd     = 5'h1F;
        tick();
        in_valid = 1'b0;
        checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL br_taken got=%0b want=1", branch_taken); end
        checks++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || out_result !== 64'hFEDC_BA98_7654_3210) begin failures++; $display("FAIL br_width pc=%h res=%h", out_pc, out_result); end
        checks++; if (out_data !== 64'h8000_0000_0000_0001 || out_rd !== 5'h1F) begin failures++; $display("FAIL br_width2 data=%h rd=%h", out_data, out_rd); end
        out_ready = 1'b1;
        tick();
        checks++; if (branch_taken !== 1'b0 || out_ctrl !== 6'b0) begin failures++; $display("FAIL br_bubble got br=%0b ctrl=%b want 0", branch_taken, out_ctrl); end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 6'b000010;
        tick();
        in_valid = 1'b0;
        checks++; if (branch_taken !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL br_not_taken got br=%0b v=%0b want 0/1", branch_taken, out_valid); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 64'h400 + 64'(4 * i);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready idx=%0d got=%0b want=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 64'h400 + 64'(4 * i)) begin failures++; $display("FAIL b2b_pc idx=%0d got v=%0b pc=%h", i, out_valid, out_pc); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL b2b_drain got=%0d want=0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_stream();
        test_flush();
        test_branch();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
